// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver and its consumer.
// The receiver (master) presents bytes and error pulses; the consumer (slave) acknowledges.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from a 50 MHz clock.
// Finds the start bit, samples each bit at mid-period and hands bytes to the
// consumer over a valid/ack handshake with framing-error and overrun pulses.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_sel,
    input  logic       rx,
    output logic       busy,
    uart_rx_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_prev_q, rx_prev_d;
    logic [1:0]  flush_q, flush_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  os_q, os_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic [15:0] div_sel;
    logic        start_det;
    logic        tick;

    // Oversample divisor for each rate code (50 MHz / (16 * baud)).
    function automatic logic [15:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'b001:  baud_div = 16'd163;
            3'b010:  baud_div = 16'd81;
            3'b011:  baud_div = 16'd54;
            3'b100:  baud_div = 16'd27;
            default: baud_div = 16'd326;
        endcase
    endfunction

    // The synchronizer powers up at the idle level, so after reset the edge
    // detector waits until rx_prev holds a genuine line sample; otherwise a
    // line held low through reset release would look like a falling edge.
    assign div_sel   = baud_div(baud_sel);
    assign start_det = (state_q == S_IDLE) && (flush_q == 2'd3) && rx_prev_q && !rx_s_q;
    assign tick      = (state_q != S_IDLE) && (cnt_q == 16'd0);

    // Next-state logic: synchronizer, baud timing, frame FSM and handshake.
    always_comb begin
        state_d   = state_q;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        flush_d   = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        div_d     = div_q;
        cnt_d     = cnt_q;
        os_d      = os_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (start_det) begin
            div_d = div_sel;
            cnt_d = div_sel - 16'd1;
        end else if (cnt_q == 16'd0) begin
            cnt_d = div_q - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end

        if (bus.rx_ack && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d = S_START;
                    os_d    = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (os_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            os_d    = 4'd0;
                            bit_d   = 3'd0;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (os_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        os_d    = 4'd0;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (os_q == 4'd15) begin
                        state_d = S_IDLE;
                        os_d    = 4'd0;
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || bus.rx_ack) begin
                            // A same-cycle ack frees the buffer, so the new byte wins.
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and outputs: synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            flush_q   <= 2'd0;
            div_q     <= 16'd326;
            cnt_q     <= 16'd0;
            os_q      <= 4'd0;
            bit_q     <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            flush_q   <= flush_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Receive shift register: pure data path, no reset needed.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign busy          = (state_q != S_IDLE);
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule
